// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings, receiver
// state encoding and the data-bit clamp helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    // Out-of-range requests saturate to the supported window.
    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
        if (req < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end
        if (req > max_bits) begin
            return max_bits;
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx synchroniser (reset to idle-high) plus the three-sample majority voter.
// The first two samples are stored; the third is the live synchronised value.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    input  logic sample_en_i,
    output logic rxs_o,
    output logic vote_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             samp_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        sync_q[gi] <= 1'b1;
                    end else begin
                        sync_q[gi] <= rx_i;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        sync_q[gi] <= 1'b1;
                    end else begin
                        sync_q[gi] <= sync_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rxs_o = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q <= 2'b11;
        end else if (sample_en_i) begin
            samp_q <= {samp_q[0], rxs_o};
        end
    end

    assign vote_o = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_o) | (samp_q[0] & rxs_o);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start-edge detection with glitch rejection,
// majority-voted bit sampling, parity/framing/break checks, valid/ready output.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     sam_tick,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               parity,
    input  logic                     stop_bits,
    output logic [MAX_DATA_BITS-1:0] data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     break_det,
    output logic                     overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] CNT_S2   = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    rx_state_t                state_q;
    logic [CW-1:0]            cnt_q;
    logic [3:0]               bit_idx_q;
    logic [3:0]               nbits_q;
    logic [1:0]               par_mode_q;
    logic                     two_stop_q;
    logic                     stop_idx_q;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic                     xor_q;
    logic                     zero_q;
    logic                     pe_q;
    logic                     fe_q;
    logic                     brk_q;

    logic [MAX_DATA_BITS-1:0] dout_q, dout_d;
    logic                     valid_q, valid_d;
    logic                     pe_out_q, pe_out_d;
    logic                     fe_out_q, fe_out_d;
    logic                     brk_out_q, brk_out_d;
    logic                     ovr_q, ovr_d;

    logic          rxs;
    logic          vote;
    logic          in_bit_state;
    logic          sample_en;
    logic          bit_tick;
    logic [CW-1:0] cnt_next;
    logic          par_en;
    logic          last_stop;
    logic          stop_fe;
    logic          stop_brk;
    logic          pe_bit;
    logic          done_c;
    logic          handshake;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .rx_i       (rx),
        .sample_en_i(sample_en),
        .rxs_o      (rxs),
        .vote_o     (vote)
    );

    assign in_bit_state = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    assign sample_en    = sam_tick && in_bit_state && ((cnt_q == CNT_S1) || (cnt_q == CNT_S2));
    assign bit_tick     = sam_tick && in_bit_state && (cnt_q == CNT_LAST);
    assign cnt_next     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    assign par_en       = (par_mode_q == PAR_ODD) || (par_mode_q == PAR_EVEN);
    assign last_stop    = (stop_idx_q == two_stop_q);
    assign stop_fe      = fe_q | ~vote;
    // Break qualification only looks at the first stop bit.
    assign stop_brk     = stop_idx_q ? brk_q : (zero_q & ~vote);
    assign pe_bit       = (par_mode_q == PAR_ODD) ? ~(xor_q ^ vote) : (xor_q ^ vote);
    assign done_c       = bit_tick && (state_q == STOP) && last_stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= 4'(MIN_DATA_BITS);
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            xor_q      <= 1'b0;
            zero_q     <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q    <= START;
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        nbits_q    <= clamp_bits(data_bits, 4'(MAX_DATA_BITS));
                        par_mode_q <= parity;
                        two_stop_q <= stop_bits;
                        stop_idx_q <= 1'b0;
                        shift_q    <= '0;
                        xor_q      <= 1'b0;
                        zero_q     <= 1'b1;
                        pe_q       <= 1'b0;
                        fe_q       <= 1'b0;
                        brk_q      <= 1'b0;
                    end
                end
                START: begin
                    if (sam_tick) begin
                        if (cnt_q == CNT_HALF) begin
                            cnt_q   <= '0;
                            state_q <= rxs ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (sam_tick) begin
                        cnt_q <= cnt_next;
                    end
                    if (bit_tick) begin
                        for (int i = 0; i < MAX_DATA_BITS; i++) begin
                            if (bit_idx_q == 4'(i)) begin
                                shift_q[i] <= vote;
                            end
                        end
                        xor_q  <= xor_q ^ vote;
                        zero_q <= zero_q & ~vote;
                        if (bit_idx_q == nbits_q - 4'd1) begin
                            state_q <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sam_tick) begin
                        cnt_q <= cnt_next;
                    end
                    if (bit_tick) begin
                        pe_q    <= pe_bit;
                        zero_q  <= zero_q & ~vote;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (sam_tick) begin
                        cnt_q <= cnt_next;
                    end
                    if (bit_tick) begin
                        fe_q  <= stop_fe;
                        brk_q <= stop_brk;
                        if (last_stop) begin
                            state_q <= stop_fe ? WAIT_HIGH : IDLE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign handshake = valid_q && data_ready;

    // A completed frame is dropped (and overrun flagged) only if the held
    // word is still waiting and is not being taken this very cycle.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        pe_out_d  = pe_out_q;
        fe_out_d  = fe_out_q;
        brk_out_d = brk_out_q;
        ovr_d     = ovr_q;
        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done_c) begin
            if (!valid_q || data_ready) begin
                dout_d    = shift_q;
                valid_d   = 1'b1;
                pe_out_d  = pe_q;
                fe_out_d  = stop_fe;
                brk_out_d = stop_brk;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            pe_out_q  <= 1'b0;
            fe_out_q  <= 1'b0;
            brk_out_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            pe_out_q  <= pe_out_d;
            fe_out_q  <= fe_out_d;
            brk_out_q <= brk_out_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign parity_err = pe_out_q;
    assign frame_err  = fe_out_q;
    assign break_det  = brk_out_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised + directed bench for uart_rx_param: a frame-level reference model
// fills a scoreboard queue; a monitor pops and compares on every handshake.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int OS   = 16;
    localparam int MAXB = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       sam_tick;
    logic [3:0] data_bits;
    logic [1:0] parity;
    logic       stop_bits;
    logic [8:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    uart_rx_param #(
        .OVERSAMPLE   (OS),
        .MAX_DATA_BITS(MAXB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .sam_tick  (sam_tick),
        .data_bits (data_bits),
        .parity    (parity),
        .stop_bits (stop_bits),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .break_det (break_det),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        sam_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 sam_tick = 1'b1;
            @(posedge clk);
            #1 sam_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 data_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word is compared with the oldest expected frame.
    always @(negedge clk) begin
        if (!reset && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data 0x%0h with none outstanding", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rx word data=0x%03h pe=%0b fe=%0b brk=%0b", data_out, parity_err, frame_err, break_det);
                check("data_out", 32'(data_out), 32'(mon_e.data));
                check("parity_err", 32'(parity_err), 32'(mon_e.pe));
                check("frame_err", 32'(frame_err), 32'(mon_e.fe));
                check("break_det", 32'(break_det), 32'(mon_e.brk));
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (sam_tick !== 1'b1);
        #2;
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        for (int t = 0; t < OS; t++) begin
            wait_tick();
            rx = (glitch && t == 7) ? ~v : v;
        end
    endtask

    // Reference model works on the frame as a whole: clamp, mask, popcount.
    task automatic send_frame(input logic [8:0] word, input logic [3:0] dbits, input logic [1:0] par,
                              input logic two, input bit flip, input logic s1, input logic s2,
                              input int glitch_bit, input bit push);
        int         nb;
        int         ones;
        logic [8:0] mask;
        logic [8:0] data;
        logic       pen;
        logic       pbit;
        exp_t       e;
        nb   = (dbits < 4'd5) ? 5 : ((int'(dbits) > MAXB) ? MAXB : int'(dbits));
        mask = 9'((1 << nb) - 1);
        data = word & mask;
        ones = $countones(data);
        pen  = (par == 2'b01) || (par == 2'b10);
        pbit = ((par == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip;
        e.data = data;
        e.pe   = pen && flip;
        e.fe   = !s1 || (two && !s2);
        e.brk  = (data == 9'd0) && (!pen || !pbit) && !s1;
        data_bits = dbits;
        parity    = par;
        stop_bits = two;
        if (push) exp_q.push_back(e);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(word[i], glitch_bit == i);
        if (pen) send_bit(pbit, 1'b0);
        send_bit(s1, 1'b0);
        if (two) send_bit(s2, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [8:0] w;
        logic [3:0] db;
        logic [1:0] pm;
        logic       two, s1, s2;
        bit         flip;
        int         gb;

        reset = 1'b1; rx = 1'b1; data_bits = 4'd8; parity = 2'b00; stop_bits = 1'b0; data_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_break_det", 32'(break_det), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // 8N1 0xA5
        send_frame(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_drain("drain_8n1");
        // 9E1 0x1FF with correct and then wrong parity bit
        send_frame(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        send_frame(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
        wait_drain("drain_9e1");
        // 7O2 0x41 with second stop bit low
        send_frame(9'h041, 4'd7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        wait_drain("drain_7o2");
        check("wait_high_state", 32'(dut.state_q), 32'(WAIT_HIGH));
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #2 check("idle_after_high", 32'(dut.state_q), 32'(IDLE));

        // Short start pulse is rejected
        wait_tick(); rx = 1'b0;
        repeat (4) wait_tick();
        rx = 1'b1;
        repeat (2 * OS) wait_tick();
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        check("glitch_no_valid", 32'(data_valid), 32'd0);
        // One-tick glitch at a data-bit centre is outvoted
        send_frame(9'h05A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1);
        wait_drain("drain_glitch");

        // Line held low for two frame times
        data_bits = 4'd8; parity = 2'b00; stop_bits = 1'b0;
        exp_q.push_back('{data: 9'd0, pe: 1'b0, fe: 1'b1, brk: 1'b1});
        wait_tick(); rx = 1'b0;
        repeat (20 * OS) wait_tick();
        wait_drain("drain_break");
        check("break_wait_high", 32'(dut.state_q), 32'(WAIT_HIGH));
        rx = 1'b1;
        repeat (2 * OS) wait_tick();
        check("break_idle", 32'(dut.state_q), 32'(IDLE));

        // Overrun: second word dropped while the first is held
        data_ready = 1'b0;
        send_frame(9'h011, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        send_frame(9'h022, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        repeat (OS) wait_tick();
        check("ovr_valid", 32'(data_valid), 32'd1);
        check("ovr_held_data", 32'(data_out), 32'h011);
        check("ovr_flag", 32'(overrun), 32'd1);
        @(posedge clk); #2 data_ready = 1'b1;
        @(posedge clk); #2;
        check("ovr_valid_clear", 32'(data_valid), 32'd0);
        check("ovr_flag_clear", 32'(overrun), 32'd0);
        wait_drain("drain_ovr");

        // Reset in the middle of a frame with a word held
        data_ready = 1'b0;
        send_frame(9'h03C, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        repeat (OS) wait_tick();
        check("pre_rst_held", 32'(data_out), 32'h03C);
        wait_tick(); rx = 1'b0;
        repeat (40) wait_tick();
        reset = 1'b1;
        #1;
        check("mid_rst_data_out", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_flags", 32'({parity_err, frame_err, break_det, overrun}), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0; data_ready = 1'b1;
        repeat (2 * OS) wait_tick();
        check("post_rst_no_valid", 32'(data_valid), 32'd0);
        send_frame(9'h05A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        wait_drain("drain_post_rst");

        // Randomised frames, random consumer back-pressure
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            w    = 9'($urandom);
            if ($urandom_range(0, 5) == 0) w = 9'd0;
            db   = 4'($urandom_range(0, 15));
            pm   = 2'($urandom_range(0, 3));
            two  = 1'($urandom_range(0, 1));
            flip = ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 7) != 0);
            s2   = ($urandom_range(0, 7) != 0);
            gb   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
            send_frame(w, db, pm, two, flip, s1, s2, gb, 1'b1);
            if (!s1 || (two && !s2) || ($urandom_range(0, 1) == 1)) send_bit(1'b1, 1'b0);
        end
        rand_ready = 1'b0;
        @(posedge clk); #3 data_ready = 1'b1;
        wait_drain("drain_random");
        check("random_no_overrun", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
